pack_sink: RTL and testbench
============================

# pack_sink

Packet sink and checker for the local (IP) port of a NoC switch. It consumes the flits the switch delivers to its own node and checks every packet for destination, length and payload sequence. It keeps sticky error flags and traffic counters, and can throttle its ready signal periodically to exercise switch buffering. It sits directly downstream of the switch local output port, in place of the receive side of the IP generator.

## Interface
- DATA_SIZE, 8, payload bits per flit
- ADDR_SIZE, 4, node address bits
- ADDR, 0, this node's address
- MAX_PACK_LEN, 8, maximum legal flits per packet (head included), ≥1
- PACKS_TO_RCV, 16, packet count at which `done` asserts
- STALL_PERIOD, 0, 0 = never stall; N≥2 = `out_r` low one cycle in every N
- Flit layout (FLIT = DATA_SIZE+ADDR_SIZE+1): [FLIT-1] last-flit flag; [FLIT-2 -: ADDR_SIZE] destination; [DATA_SIZE-1:0] payload

- clk  in  1  clock, rising edge
- a_rst  in  1  reset, asynchronous, active-low
- data_i  in  FLIT  flit from switch
- in_w  in  1  flit valid from switch
- out_r  out  1  sink ready (registered)
- flits_rcv  out  32  accepted flits, wraps mod 2^32
- packs_rcv  out  32  completed packets (tail accepted), wraps
- last_src  out  ADDR_SIZE  source of last completed packet
- last_len  out  8  flit count of last completed packet (saturates 255)
- err_addr, err_seq, err_len  out  1 each  sticky error flags
- done  out  1  packs_rcv ≥ PACKS_TO_RCV; sticky until reset

## Operation
- Transfer: occurs on a rising edge with in_w=1 and out_r=1. Nothing is consumed otherwise, and the switch holds data_i.
- Payload convention:
  - head flit payload[ADDR_SIZE-1:0] = source address
  - body flit k (k=1,2,…) payload = k mod 2^DATA_SIZE
- FSM, two states:
  - S_HEAD: waiting for head. On transfer: latch src, set len=1, expected=1.
    - last=1 → packet complete, stay in S_HEAD.
    - else → S_BODY.
  - S_BODY: on transfer: compare payload with expected, then expected++, len++.
    - last=1 → complete, go to S_HEAD.
- Checks on every accepted flit:
  - dest ≠ ADDR → err_addr.
  - Body payload ≠ expected → err_seq. The expected value does not resync; it keeps incrementing.
  - len exceeds MAX_PACK_LEN → err_len, set once per packet. The block keeps consuming until the tail and never drops flits.
- Completion (tail accepted): packs_rcv++, last_src←src (head's src if single-flit), last_len←len including tail.
- Stall generator:
  - mod-N counter runs freely from reset.
  - out_r=0 when counter==N-1, else 1.
  - STALL_PERIOD 0 or 1 → out_r=1 always after reset.
- Error flags and done clear only on reset.

## Timing
- While a_rst=0: out_r=0, all counters 0, last_src=0, last_len=0, all flags 0, FSM in S_HEAD, stall counter 0.
- out_r first goes 1 at the first rising edge after a_rst deasserts.
- All outputs are registered. Counters, flags, last_* and done reflect a transfer one cycle after its edge, i.e. visible after the accepting edge.
- Throughput: one flit per cycle when not stalled; no bubbles between packets.
- Simultaneous tail + new head is impossible (one flit per cycle). A head with last=1 completes in one cycle.
- in_w=1 during a stall cycle: no state change; the same flit is accepted on the next ready edge.
- Reset mid-packet: FSM returns to S_HEAD. The partial packet is forgotten and not counted as an error.
- Wrap: flits_rcv and packs_rcv roll from 2^32-1 to 0. done remains 1 (sticky).

## Test plan
- Reset: hold a_rst=0 5 cycles with in_w=1 → out_r=0 and all outputs 0; out_r=1 the edge after release.
- Single 4-flit packet, ADDR=3, src=5, payloads 5,1,2,3, last on flit 4 → flits_rcv=4, packs_rcv=1, last_src=5, last_len=4, no errors.
- Misrouted and bad sequence: a flit with dest=2 → err_addr=1. Body payloads 1,3 → err_seq=1. Both stay set across later clean packets.
- Overlength: MAX_PACK_LEN=8 and a 10-flit packet → err_len=1, packs_rcv++, last_len=10. A following 2-flit packet is received normally.
- Stall: STALL_PERIOD=4 with continuous in_w over 40 cycles → out_r low every 4th cycle, flits_rcv=30, flits held during stalls are not lost or duplicated.
- done: PACKS_TO_RCV=3, send 3 single-flit packets → done rises the cycle after the 3rd tail. Reset mid-way through a 4th packet → everything clears, and the next packet is counted from 1.

Source files
------------

// File: rtl/pack_sink.sv
// Receive-side packet checker for a NoC switch local port.
// Counts flits/packets, checks destination, length and body sequence, optionally throttles ready.
//   state  | meaning
//   S_HEAD | waiting for the head flit of the next packet
//   S_BODY | head accepted, consuming body flits until the tail
module pack_sink #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 4,
    parameter int ADDR         = 0,
    parameter int MAX_PACK_LEN = 8,
    parameter int PACKS_TO_RCV = 16,
    parameter int STALL_PERIOD = 0,
    parameter int FLIT         = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [FLIT-1:0]      data_i,
    input  logic                 in_w,
    output logic                 out_r,
    output logic [31:0]          flits_rcv,
    output logic [31:0]          packs_rcv,
    output logic [ADDR_SIZE-1:0] last_src,
    output logic [7:0]           last_len,
    output logic                 err_addr,
    output logic                 err_seq,
    output logic                 err_len,
    output logic                 done
);

    localparam logic [31:0]          PACKS_TGT = 32'(PACKS_TO_RCV);
    localparam logic [ADDR_SIZE-1:0] MY_ADDR   = ADDR_SIZE'(ADDR);

    typedef enum logic {S_HEAD, S_BODY} state_t;

    state_t                 state, state_nx;
    logic [ADDR_SIZE-1:0]   src, src_nx;
    logic [7:0]             len, len_nx;
    logic [DATA_SIZE-1:0]   expected, exp_nx;
    logic [31:0]            packs_nx;
    logic                   complete, seq_bad, len_bad;

    logic                   xfer;
    logic                   last_f;
    logic [ADDR_SIZE-1:0]   dest;
    logic [DATA_SIZE-1:0]   payload;

    assign xfer    = in_w & out_r;
    assign last_f  = data_i[FLIT-1];
    assign dest    = data_i[FLIT-2 -: ADDR_SIZE];
    assign payload = data_i[DATA_SIZE-1:0];

    // Registered ready: low in the cycle after every STALL_PERIOD-th edge, never right after reset.
    generate
        if (STALL_PERIOD >= 2) begin : g_stall
            localparam int             SW   = $clog2(STALL_PERIOD);
            localparam logic [SW-1:0]  LAST = SW'(STALL_PERIOD - 1);
            logic [SW-1:0] stall_cnt;

            always_ff @(posedge clk or negedge a_rst) begin
                if (!a_rst) begin
                    stall_cnt <= '0;
                    out_r     <= 1'b0;
                end else begin
                    stall_cnt <= (stall_cnt == LAST) ? '0 : stall_cnt + SW'(1);
                    out_r     <= (stall_cnt != LAST);
                end
            end
        end else begin : g_no_stall
            always_ff @(posedge clk or negedge a_rst) begin
                if (!a_rst) out_r <= 1'b0;
                else        out_r <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state    <= S_HEAD;
            src      <= '0;
            len      <= '0;
            expected <= '0;
        end else begin
            state    <= state_nx;
            src      <= src_nx;
            len      <= len_nx;
            expected <= exp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        src_nx   = src;
        len_nx   = len;
        exp_nx   = expected;
        complete = 1'b0;
        seq_bad  = 1'b0;
        len_bad  = 1'b0;
        if (xfer) begin
            case (state)
                S_HEAD: begin
                    src_nx   = payload[ADDR_SIZE-1:0];
                    len_nx   = 8'd1;
                    exp_nx   = DATA_SIZE'(1);
                    complete = last_f;
                    if (!last_f) state_nx = S_BODY;
                end
                S_BODY: begin
                    // Expected keeps counting after a mismatch so one bad flit flags once, not every flit after.
                    seq_bad  = (payload != expected);
                    exp_nx   = expected + DATA_SIZE'(1);
                    len_nx   = (len == 8'hFF) ? len : len + 8'd1;
                    len_bad  = (int'(len_nx) > MAX_PACK_LEN);
                    complete = last_f;
                    if (last_f) state_nx = S_HEAD;
                end
                default: state_nx = S_HEAD;
            endcase
        end
    end

    assign packs_nx = packs_rcv + (complete ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            flits_rcv <= '0;
            packs_rcv <= '0;
            last_src  <= '0;
            last_len  <= '0;
            err_addr  <= 1'b0;
            err_seq   <= 1'b0;
            err_len   <= 1'b0;
            done      <= 1'b0;
        end else begin
            packs_rcv <= packs_nx;
            done      <= done | (packs_nx >= PACKS_TGT);
            err_seq   <= err_seq | seq_bad;
            err_len   <= err_len | len_bad;
            if (xfer) begin
                flits_rcv <= flits_rcv + 32'd1;
                err_addr  <= err_addr | (dest != MY_ADDR);
            end
            if (complete) begin
                last_src <= src_nx;
                last_len <= len_nx;
            end
        end
    end

endmodule

// File: tb/tb_pack_sink.sv
// Scoreboard bench for pack_sink: packet-level reference model feeds a queue, a monitor pops on completion.
module tb_pack_sink;

    localparam int PERIOD = 4;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [12:0] data_i;
    logic        in_w;
    logic        out_r;
    logic [31:0] flits_rcv, packs_rcv;
    logic [3:0]  last_src;
    logic [7:0]  last_len;
    logic        err_addr, err_seq, err_len, done;

    pack_sink #(
        .DATA_SIZE(8), .ADDR_SIZE(4), .ADDR(3), .MAX_PACK_LEN(8),
        .PACKS_TO_RCV(3), .STALL_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .a_rst(a_rst), .data_i(data_i), .in_w(in_w), .out_r(out_r),
        .flits_rcv(flits_rcv), .packs_rcv(packs_rcv), .last_src(last_src),
        .last_len(last_len), .err_addr(err_addr), .err_seq(err_seq),
        .err_len(err_len), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] flits;
        logic [31:0] packs;
        logic [3:0]  src;
        logic [7:0]  len;
        logic        ea, es, el, dn;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int edge_cnt;
    logic [31:0] prev_packs;

    int unsigned m_flits, m_packs;
    bit          m_ea, m_es, m_el;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic last, input logic [3:0] dest, input logic [7:0] pl);
        return {last, dest, pl};
    endfunction

    always @(posedge clk or negedge a_rst) begin
        if (!a_rst) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Ready is high after edge k unless k is a multiple of PERIOD; it is low out of reset (k=0).
    function automatic bit ready_pred();
        return (edge_cnt % PERIOD) != 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!a_rst) begin
            prev_packs = '0;
        end else begin
            chk("out_r", 32'(out_r), 32'(ready_pred()));
            if (packs_rcv != prev_packs) begin
                prev_packs = packs_rcv;
                if (q.size() == 0) begin
                    chk("unexpected_pack", packs_rcv, 32'(m_packs));
                end else begin
                    e = q.pop_front();
                    chk("flits_rcv", flits_rcv, e.flits);
                    chk("packs_rcv", packs_rcv, e.packs);
                    chk("last_src", 32'(last_src), 32'(e.src));
                    chk("last_len", 32'(last_len), 32'(e.len));
                    chk("err_addr", 32'(err_addr), 32'(e.ea));
                    chk("err_seq", 32'(err_seq), 32'(e.es));
                    chk("err_len", 32'(err_len), 32'(e.el));
                    chk("done", 32'(done), 32'(e.dn));
                end
            end
        end
    end

    task automatic push_expect(input int n, input logic [3:0] src, input bit ea, input bit es);
        exp_t e;
        m_flits += n;
        m_packs++;
        m_ea |= ea;
        m_es |= es;
        m_el |= (n > 8);
        e.flits = m_flits;
        e.packs = m_packs;
        e.src   = src;
        e.len   = (n > 255) ? 8'd255 : 8'(n);
        e.ea    = m_ea;
        e.es    = m_es;
        e.el    = m_el;
        e.dn    = (m_packs >= 3);
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_flits = 0; m_packs = 0;
        m_ea = 0; m_es = 0; m_el = 0;
    endtask

    // Present a flit from a negedge and hold it until the predicted ready edge takes it.
    task automatic drive_flit(input logic [12:0] f);
        bit acc = 0;
        data_i = f;
        in_w   = 1'b1;
        for (int t = 0; t < 8 && !acc; t++) begin
            acc = ready_pred();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        in_w   = 1'b0;
        data_i = 13'($urandom);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_pkt(input int n, input logic [3:0] src, input int bad_dest,
                            input int bad_seq, input int gap);
        logic [12:0] pkt[$];
        logic [7:0]  pl;
        logic [3:0]  d;
        bit          ea = 0, es = 0;
        for (int k = 0; k < n; k++) begin
            pl = (k == 0) ? {4'($urandom), src} : 8'(k);
            if (k == bad_seq && k > 0) pl = pl + 8'd1;
            d = 4'd3;
            if (k == bad_dest) begin
                d = 4'($urandom_range(0, 15));
                if (d == 4'd3) d = 4'd2;
            end
            pkt.push_back(mk(k == n - 1, d, pl));
        end
        foreach (pkt[k]) begin
            if (pkt[k][11:8] != 4'd3) ea = 1;
            if (k > 0 && pkt[k][7:0] != 8'(k)) es = 1;
        end
        if (gap > 0) idle(gap);
        push_expect(n, src, ea, es);
        foreach (pkt[k]) drive_flit(pkt[k]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_r"}, 32'(out_r), 32'd0);
        chk({tag, "_flits"}, flits_rcv, 32'd0);
        chk({tag, "_packs"}, packs_rcv, 32'd0);
        chk({tag, "_src"}, 32'(last_src), 32'd0);
        chk({tag, "_len"}, 32'(last_len), 32'd0);
        chk({tag, "_flags"}, 32'({err_addr, err_seq, err_len, done}), 32'd0);
    endtask

    initial begin
        int i;
        bit acc;
        model_reset();
        a_rst  = 1'b0;
        in_w   = 1'b1;
        data_i = mk(1'b1, 4'd3, 8'd0);
        repeat (5) @(negedge clk);
        chk_all_zero("rst");
        a_rst = 1'b1;

        // Continuous single-flit packets for 40 edges straight out of reset.
        i = 0;
        for (int c = 0; c < 40; c++) begin
            acc = ready_pred();
            if (acc) push_expect(1, 4'(i), 0, 0);
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                i++;
                data_i = mk(1'b1, 4'd3, 8'(i));
            end
        end
        chk("stall_flits", flits_rcv, 32'd30);
        idle(3);

        send_pkt(4, 4'd5, -1, -1, 1);
        for (int p = 0; p < 8; p++)
            send_pkt($urandom_range(1, 8), 4'($urandom), -1, -1, $urandom_range(0, 3));

        send_pkt(3, 4'd7, 1, -1, 1);
        send_pkt(3, 4'd6, -1, 2, 0);
        send_pkt(2, 4'd1, -1, -1, 2);
        send_pkt(10, 4'd9, -1, -1, 1);
        send_pkt(2, 4'd4, -1, -1, 0);

        for (int p = 0; p < 20; p++) begin
            int n;
            n = $urandom_range(1, 12);
            send_pkt(n, 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : -1,
                     $urandom_range(0, 2));
        end
        idle(3);
        chk("pending_before_reset", 32'(q.size()), 32'd0);

        // Partial packet, then reset in the middle of it.
        drive_flit(mk(1'b0, 4'd3, 8'h09));
        drive_flit(mk(1'b0, 4'd3, 8'h01));
        a_rst = 1'b0;
        in_w  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        a_rst = 1'b1;

        send_pkt(4, 4'd5, -1, -1, 0);
        for (int p = 0; p < 3; p++)
            send_pkt($urandom_range(1, 5), 4'($urandom), -1, -1, $urandom_range(0, 2));
        idle(5);
        chk("pending_end", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
